// File: rtl/seg7_pkg.sv
// Shared types and constants for the BCD 7-segment display slice.
// Glyphs are active-low, written a..g from MSB to LSB (seg[0]=a).
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } conv_state_e;

  localparam int unsigned DIGIT_N   = 4;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  localparam logic [9:0][6:0] GLYPH_TBL = {
    7'h04, 7'h00, 7'h0F, 7'h20, 7'h24,
    7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    seg_decode = SEG_BLANK;
    if (nib <= 4'd9) seg_decode = GLYPH_TBL[nib];
  endfunction

endpackage

// File: rtl/seg7_bcd_display_if.sv
// Load/status bus between the writeback stage and the display block.
interface seg7_bcd_display_if;
  logic [7:0] i_data;
  logic       i_load;
  logic [3:0] i_dp;
  logic       o_busy;

  modport master (output i_data, output i_load, output i_dp, input o_busy);
  modport slave  (input i_data, input i_load, input i_dp, output o_busy);
endinterface

// File: rtl/bin2bcd_dd.sv
// Sequential double-dabble: 8-bit binary to 3 BCD digits in 8 shift cycles.
// A start seen in DONE restarts immediately so back-to-back conversions do not idle.
module bin2bcd_dd
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_e state, state_nx;
  logic [19:0] sr;
  logic [19:0] sr_nx;
  logic [2:0]  bitcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CONV;
      CONV:    if (bitcnt == 3'd7) state_nx = DONE;
      DONE:    state_nx = start ? CONV : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_comb begin
    sr_nx = sr;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sr_nx[8 + 4*i +: 4] >= 4'd5) sr_nx[8 + 4*i +: 4] = sr_nx[8 + 4*i +: 4] + 4'd3;
    end
    sr_nx = {sr_nx[18:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      bitcnt <= '0;
    end else if (start && (state != CONV)) begin
      sr     <= {12'b0, bin};
      bitcnt <= '0;
    end else if (state == CONV) begin
      sr     <= sr_nx;
      bitcnt <= bitcnt + 3'd1;
    end
  end

  assign bcd = sr[19:8];

endmodule

// File: rtl/seg7_bcd_display.sv
// 4-digit common-anode display of an 8-bit value: BCD conversion, pending-load
// coalescing, digit refresh, leading-zero blanking and registered outputs.
module seg7_bcd_display
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DATA_W      = 8
) (
  input  logic                 clk_100mhz,
  input  logic                 i_rst_n,
  seg7_bcd_display_if.slave    bus,
  output logic [0:6]           seg,
  output logic [3:0]           digit,
  output logic                 dp
);

  localparam int unsigned RCNT_W = $clog2(REFRESH_DIV);

  logic              conv_start;
  logic [7:0]        conv_bin;
  logic              conv_busy;
  logic              conv_done;
  logic [11:0]       conv_bcd;

  logic              pending;
  logic [DATA_W-1:0] pend_data;
  logic [11:0]       done_bcd;
  logic              upd_q;
  logic [11:0]       disp_bcd;

  logic [RCNT_W-1:0] rcnt;
  logic [1:0]        idx;
  logic [6:0]        glyph;

  // A load arriving in DONE wins over the stored pending value (it is newer).
  assign conv_start = conv_busy ? (conv_done && (pending || bus.i_load)) : bus.i_load;
  assign conv_bin   = bus.i_load ? bus.i_data : pend_data;

  bin2bcd_dd u_conv (
    .clk   (clk_100mhz),
    .rst_n (i_rst_n),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk_100mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending   <= 1'b0;
      pend_data <= '0;
    end else if (conv_done) begin
      pending   <= 1'b0;
    end else if (bus.i_load && conv_busy) begin
      pending   <= 1'b1;
      pend_data <= bus.i_data;
    end
  end

  // Result is staged once so all three display digits switch on a single edge.
  always_ff @(posedge clk_100mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      done_bcd <= '0;
      upd_q    <= 1'b0;
      disp_bcd <= '0;
    end else begin
      upd_q <= conv_done;
      if (conv_done) done_bcd <= conv_bcd;
      if (upd_q)     disp_bcd <= done_bcd;
    end
  end

  assign bus.o_busy = conv_busy || upd_q || pending;

  always_ff @(posedge clk_100mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RCNT_W'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  always_comb begin
    glyph = SEG_BLANK;
    case (idx)
      2'd0: glyph = seg_decode(disp_bcd[3:0]);
      2'd1: if (disp_bcd[11:4] != 8'd0) glyph = seg_decode(disp_bcd[7:4]);
      2'd2: if (disp_bcd[11:8] != 4'd0) glyph = seg_decode(disp_bcd[11:8]);
      default: glyph = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seg   <= SEG_BLANK;
      digit <= '1;
      dp    <= 1'b1;
    end else begin
      seg   <= glyph;
      digit <= ~(4'b0001 << idx);
      dp    <= ~bus.i_dp[idx];
    end
  end

endmodule
